sd_cmd_rsp_rx: RTL and testbench
================================

# sd_cmd_rsp_rx

Serial receiver and CRC7 checker for 48-bit SD command-line frames: the receive-side counterpart of the host CRC7 generator. It waits for a start bit on the CMD line and deserializes the frame. It checks the CRC over the 40 content bits against the received CRC7, checks the framing bits, and reports the result with a one-cycle `done` pulse. It sits between the CMD pad sampler and the SD host command FSM.

## Interface
- `TIMEOUT_CYC`, default 64: number of `bit_en` strobes allowed in WAIT_START before a timeout (NCR limit).
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `Enable`  in  1  level; high arms and keeps the receiver running; low aborts and returns it to IDLE.
- `bit_en`  in  1  one-CLK strobe marking a valid CMD-line sample (SD clock edge).
- `cmd_i`  in  1  sampled CMD line; meaningful only when `bit_en`=1.
- `rsp_o`  out  40  received content bits [47:8], MSB first (start bit at [39]).
- `crc_o`  out  7  received CRC7 field.
- `done`  out  1  one-cycle pulse; frame complete or timeout.
- `crc_err`  out  1  valid with `done`; computed CRC ≠ received CRC.
- `frame_err`  out  1  valid with `done`; end bit ≠ 1.
- `timeout`  out  1  valid with `done`; no start bit within `TIMEOUT_CYC` strobes.

## Operation
- States: IDLE, WAIT_START, SHIFT, CHECK, DONE.
- IDLE: clear the CRC register, bit counter and timeout counter. Go to WAIT_START when `Enable`=1.
- WAIT_START: on `bit_en` with `cmd_i`=0, feed the start bit into the CRC, load the counter with 1, and go to SHIFT. On `bit_en` with `cmd_i`=1, increment the timeout counter.
- SHIFT: on each `bit_en`, shift `cmd_i` into the 48-bit shift register and increment the counter (6 bits).
  - Bits 1–39 are fed into the CRC.
  - Bits 40–46 are captured as the received CRC and are not fed in.
  - Bit 47 is the end bit. After it is sampled, go to CHECK.
- CRC7: polynomial x^7+x^3+1, initial value 0, MSB-first. `inv` = bit ^ crc[6]. Update: crc <= {crc[5:4]... shift left, crc[3] ^= inv, crc[0] = inv}. This is bit-exact with the host generator.
- CHECK: one cycle. Register `rsp_o`, `crc_o`, `crc_err` and `frame_err`, then go to DONE.
- DONE: assert `done` for one cycle, then go to IDLE. Re-arming requires `Enable` to be low for at least one cycle and then high again.
- `Enable` falling in any state except DONE: return to IDLE immediately. No `done` pulse; outputs keep their previous values.
- The transmission bit is not checked. It is reported at `rsp_o[38]`.
- `bit_en` is ignored in IDLE, CHECK and DONE.

## Timing
- Reset values: `rsp_o`=0, `crc_o`=0, `done`=0, `crc_err`=0, `frame_err`=0, `timeout`=0; state IDLE.
- Reset is asynchronous and may occur mid-frame: return to IDLE at once and discard the partial frame.
- Latency: the end bit is sampled at edge N. The state is CHECK during cycle N+1. `done` is high during cycle N+2 only.
- `rsp_o`, `crc_o` and the error flags update at edge N+2 and hold until the next completed frame or timeout.
- Timeout: the `TIMEOUT_CYC`-th strobe with `cmd_i`=1 moves the FSM to DONE with `timeout`=1, `crc_err`=0 and `frame_err`=0. `rsp_o` and `crc_o` are unchanged.
- `bit_en` may be asserted on consecutive CLK cycles (full rate). There is no minimum gap.

## Configuration
- `SD_RSP_TIMEOUT_EN` defined: the timeout counter and `timeout` output are active, as described above.
- `SD_RSP_TIMEOUT_EN` undefined: WAIT_START waits indefinitely and `timeout` is tied to 0. `TIMEOUT_CYC` is unused and the counter is not built.

## Structure
- Shared package `sd_pkg`:
  - FSM state encoding;
  - `SD_FRAME_BITS`=48 and `SD_CRC_FIRST`=40;
  - CRC7 tap constant 7'h09.
- Sub-module `crc7_serial`: ports `CLK`, `RST`, `clr`, `en`, `bit_i`, `crc_o[6:0]`. It is reusable by the host generator rework.

## Test plan
- CMD0 frame 0x40_0000_0000_95, bits at full-rate `bit_en` → `done` at N+2, `crc_o`=0x4A, `rsp_o`=0x40_0000_0000, `crc_err`=0, `frame_err`=0.
- CMD8 frame 0x48_0000_01AA_87 with `bit_en` every 3rd cycle and 5 idle 1-bits before the start bit → `crc_o`=0x43, no errors.
- CMD0 frame with argument bit 0 flipped (0x40_0000_0001_95) → `crc_err`=1, `frame_err`=0.
- CMD0 frame with end bit 0 (last byte 0x94) → `frame_err`=1, `crc_err`=0.
- `cmd_i` held 1 for 64 strobes (macro defined) → `done`=1 and `timeout`=1 on the 64th strobe +1 cycle. With the macro undefined → no `done`.
- Drop `Enable` at bit 20, then separately assert `RST`=0 at bit 30 → no `done` in either case. A following clean CMD0 frame is received correctly.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared definitions for the SD command-line receive path: FSM encoding,
// frame geometry and the CRC7 (x^7 + x^3 + 1) single-bit update.
package sd_pkg;

  localparam int SD_FRAME_BITS = 48;  // start .. end bit
  localparam int SD_CRC_FIRST  = 40;  // index of the first CRC7 bit in the frame

  localparam logic [6:0] SD_CRC7_TAPS = 7'h09;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_SHIFT      = 3'd2,
    ST_CHECK      = 3'd3,
    ST_DONE       = 3'd4
  } sd_rx_state_e;

  // One MSB-first CRC7 step. The feedback bit is the incoming bit xor the
  // register MSB; it is injected at bit 0 and bit 3.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic inv;
    inv = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (inv ? SD_CRC7_TAPS : 7'h00);
  endfunction

endpackage

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 register shared by the SD receive checker and the host
// command generator. Synchronous clear has priority over the enable.
module crc7_serial
  import sd_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       clr,
  input  logic       en,
  input  logic       bit_i,
  output logic [6:0] crc_o
);

  logic [6:0] crc_q, crc_d;

  // next CRC value: clear, advance by one bit, or hold
  always_comb begin
    crc_d = crc_q;
    if (clr) begin
      crc_d = 7'h00;
    end else if (en) begin
      crc_d = crc7_step(crc_q, bit_i);
    end
  end

  // CRC register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      crc_q <= 7'h00;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/sd_cmd_rsp_rx.sv
// SD CMD-line frame receiver: waits for a start bit, deserializes the
// 48-bit frame, checks CRC7 over the 40 content bits and the end bit, and
// reports the result with a one-cycle done pulse.
// Build option: SD_RSP_TIMEOUT_EN enables the no-start-bit timeout counter.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | cleared; waits for Enable (re-armed after a low phase)
//   WAIT_START | CMD idles high; first sampled 0 is the start bit
//   SHIFT      | collects bits 1..47; CRC fed through bit 39
//   CHECK      | compares CRCs, checks end bit, registers results
//   DONE       | one-cycle done pulse, then back to IDLE
module sd_cmd_rsp_rx
  import sd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        Enable,
  input  logic        bit_en,
  input  logic        cmd_i,
  output logic [39:0] rsp_o,
  output logic [6:0]  crc_o,
  output logic        done,
  output logic        crc_err,
  output logic        frame_err,
  output logic        timeout
);

  localparam logic [5:0] FRAME_END = 6'(SD_FRAME_BITS);
  localparam logic [5:0] CRC_FIRST = 6'(SD_CRC_FIRST);

  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("sd_cmd_rsp_rx: TIMEOUT_CYC must be at least 1");
  end

  sd_rx_state_e state_q, state_d;

  logic        rearm_blk_q, rearm_blk_d;
  logic [47:0] sr_q, sr_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [39:0] rsp_q, rsp_d;
  logic [6:0]  crc_rx_q, crc_rx_d;
  logic        crc_err_q, crc_err_d;
  logic        frame_err_q, frame_err_d;

  logic [6:0]  crc_calc;
  logic        tmo_tc;

  // FSM control strobes
  logic crc_clr, crc_en;
  logic sr_shift;
  logic cnt_clr, cnt_load1, cnt_inc;
  logic cap_frame, cap_tmo;
  logic done_c;

  // ------------------------------------------------------------------
  // FSM
  // ------------------------------------------------------------------

  // state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic; Enable low aborts everywhere except the done pulse
  always_comb begin
    state_d = state_q;
    if (!Enable && (state_q != ST_DONE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (Enable && !rearm_blk_q) state_d = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (bit_en && !cmd_i)      state_d = ST_SHIFT;
          else if (bit_en && tmo_tc) state_d = ST_DONE;
        end
        ST_SHIFT: begin
          if (cnt_q == FRAME_END) state_d = ST_CHECK;
        end
        ST_CHECK: state_d = ST_DONE;
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // output/control decode; captures are gated by Enable so an abort
  // leaves the reported results untouched
  always_comb begin
    crc_clr   = 1'b0;
    crc_en    = 1'b0;
    sr_shift  = 1'b0;
    cnt_clr   = 1'b0;
    cnt_load1 = 1'b0;
    cnt_inc   = 1'b0;
    cap_frame = 1'b0;
    cap_tmo   = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        crc_clr = 1'b1;
        cnt_clr = 1'b1;
      end
      ST_WAIT_START: begin
        if (Enable && bit_en) begin
          if (!cmd_i) begin
            crc_en    = 1'b1;
            sr_shift  = 1'b1;
            cnt_load1 = 1'b1;
          end else if (tmo_tc) begin
            cap_tmo = 1'b1;
          end
        end
      end
      ST_SHIFT: begin
        if (Enable && bit_en && (cnt_q < FRAME_END)) begin
          sr_shift = 1'b1;
          cnt_inc  = 1'b1;
          crc_en   = (cnt_q < CRC_FIRST);
        end
      end
      ST_CHECK: begin
        cap_frame = Enable;
      end
      ST_DONE: begin
        done_c = 1'b1;
      end
      default: ;
    endcase
  end

  // re-arm lockout: set when a pulse completes with Enable still high,
  // released by any cycle with Enable low
  always_comb begin
    rearm_blk_d = rearm_blk_q;
    if (!Enable) begin
      rearm_blk_d = 1'b0;
    end else if (state_q == ST_DONE) begin
      rearm_blk_d = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Datapath
  // ------------------------------------------------------------------

  crc7_serial u_crc (
    .CLK   (CLK),
    .RST   (RST),
    .clr   (crc_clr),
    .en    (crc_en),
    .bit_i (cmd_i),
    .crc_o (crc_calc)
  );

  // shift register, bit counter and result capture
  always_comb begin
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    rsp_d       = rsp_q;
    crc_rx_d    = crc_rx_q;
    crc_err_d   = crc_err_q;
    frame_err_d = frame_err_q;

    if (sr_shift) sr_d = {sr_q[46:0], cmd_i};

    if (cnt_clr)        cnt_d = 6'd0;
    else if (cnt_load1) cnt_d = 6'd1;
    else if (cnt_inc)   cnt_d = cnt_q + 6'd1;

    if (cap_frame) begin
      rsp_d       = sr_q[47:8];
      crc_rx_d    = sr_q[7:1];
      crc_err_d   = (crc_calc != sr_q[7:1]);
      frame_err_d = ~sr_q[0];
    end else if (cap_tmo) begin
      crc_err_d   = 1'b0;
      frame_err_d = 1'b0;
    end
  end

  // datapath and lockout registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rearm_blk_q <= 1'b0;
      sr_q        <= '0;
      cnt_q       <= '0;
      rsp_q       <= '0;
      crc_rx_q    <= '0;
      crc_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rearm_blk_q <= rearm_blk_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      rsp_q       <= rsp_d;
      crc_rx_q    <= crc_rx_d;
      crc_err_q   <= crc_err_d;
      frame_err_q <= frame_err_d;
    end
  end

`ifdef SD_RSP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_flag_q, tmo_flag_d;

  // NCR down-counter: loaded in IDLE, one step per idle-high strobe
  always_comb begin
    tmo_d      = tmo_q;
    tmo_flag_d = tmo_flag_q;
    if (state_q == ST_IDLE) begin
      tmo_d = TW'(TIMEOUT_CYC);
    end else if ((state_q == ST_WAIT_START) && bit_en && cmd_i) begin
      tmo_d = tmo_q - TW'(1);
    end
    if (cap_tmo)        tmo_flag_d = 1'b1;
    else if (cap_frame) tmo_flag_d = 1'b0;
  end

  // timeout counter and flag registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tmo_q      <= TW'(TIMEOUT_CYC);
      tmo_flag_q <= 1'b0;
    end else begin
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign tmo_tc  = (tmo_q == TW'(1)) && cmd_i;
  assign timeout = tmo_flag_q;
`else
  assign tmo_tc  = 1'b0;
  assign timeout = 1'b0;
`endif

  assign rsp_o     = rsp_q;
  assign crc_o     = crc_rx_q;
  assign crc_err   = crc_err_q;
  assign frame_err = frame_err_q;
  assign done      = done_c;

endmodule

// File: tb/tb_sd_cmd_rsp_rx.sv
// Directed bench for sd_cmd_rsp_rx with a scoreboard of expected frame
// results, popped and compared whenever done pulses.
module tb_sd_cmd_rsp_rx;

  logic        CLK;
  logic        RST;
  logic        Enable;
  logic        bit_en;
  logic        cmd_i;
  logic [39:0] rsp_o;
  logic [6:0]  crc_o;
  logic        done;
  logic        crc_err;
  logic        frame_err;
  logic        timeout;

  sd_cmd_rsp_rx #(.TIMEOUT_CYC(64)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Enable    (Enable),
    .bit_en    (bit_en),
    .cmd_i     (cmd_i),
    .rsp_o     (rsp_o),
    .crc_o     (crc_o),
    .done      (done),
    .crc_err   (crc_err),
    .frame_err (frame_err),
    .timeout   (timeout)
  );

  typedef struct {
    logic [39:0] rsp;
    logic [6:0]  crc;
    logic        ce;
    logic        fe;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  logic prev_done = 1'b0;

  localparam logic [47:0] F_CMD0     = 48'h40_0000_0000_95;
  localparam logic [47:0] F_CMD8     = 48'h48_0000_01AA_87;
  localparam logic [47:0] F_CMD0_ARG = 48'h40_0000_0001_95;
  localparam logic [47:0] F_CMD0_END = 48'h40_0000_0000_94;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish in time");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [39:0] rsp, input logic [6:0] crc,
                              input logic ce, input logic fe, input logic to);
    exp_t e;
    e.rsp = rsp; e.crc = crc; e.ce = ce; e.fe = fe; e.to = to; e.cyc = 0;
    return e;
  endfunction

  // Monitor: every done pops one expectation; done must last one cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (RST) begin
        if (prev_done) check("done_width", 64'(done), 64'd0);
        if (done) begin
          check("spurious_done", 64'(sb.size() != 0), 64'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check("rsp_o",     64'(rsp_o),     64'(e.rsp));
            check("crc_o",     64'(crc_o),     64'(e.crc));
            check("crc_err",   64'(crc_err),   64'(e.ce));
            check("frame_err", 64'(frame_err), 64'(e.fe));
            check("timeout",   64'(timeout),   64'(e.to));
            check("done_cyc",  64'(cyc),       64'(e.cyc));
          end
        end
        prev_done = done;
      end else begin
        prev_done = 1'b0;
      end
    end
  end

  task automatic arm();
    @(negedge CLK); Enable = 1'b0; bit_en = 1'b0; cmd_i = 1'b1;
    @(negedge CLK);
    @(negedge CLK); Enable = 1'b1;
    @(negedge CLK);
  endtask

  task automatic strobe(input logic b, input int gap);
    @(negedge CLK); bit_en = 1'b1; cmd_i = b;
    repeat (gap - 1) begin
      @(negedge CLK); bit_en = 1'b0;
    end
  endtask

  // Sends pre idle-high bits and then the first nbits of f, MSB first.
  // Done is due in the third cycle after the cycle that carries the end bit.
  task automatic send(input logic [47:0] f, input int nbits, input int gap,
                      input int pre, input exp_t e, input bit push);
    for (int i = 0; i < pre; i++) strobe(1'b1, gap);
    for (int i = 0; i < nbits; i++) begin
      @(negedge CLK); bit_en = 1'b1; cmd_i = f[47 - i];
      if (push && (i == nbits - 1)) begin
        e.cyc = cyc + 3;
        sb.push_back(e);
      end
      repeat (gap - 1) begin
        @(negedge CLK); bit_en = 1'b0;
      end
    end
    @(negedge CLK); bit_en = 1'b0; cmd_i = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0) break;
      @(negedge CLK);
    end
    check(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_outputs(input string tag, input logic [39:0] rsp, input logic [6:0] crc,
                               input logic ce, input logic fe, input logic to);
    check({tag, "_rsp"},   64'(rsp_o),     64'(rsp));
    check({tag, "_crc"},   64'(crc_o),     64'(crc));
    check({tag, "_ce"},    64'(crc_err),   64'(ce));
    check({tag, "_fe"},    64'(frame_err), 64'(fe));
    check({tag, "_to"},    64'(timeout),   64'(to));
    check({tag, "_done"},  64'(done),      64'd0);
  endtask

  initial begin
    exp_t e;
    logic last_to;
    RST = 1'b0; Enable = 1'b0; bit_en = 1'b0; cmd_i = 1'b1;
    repeat (3) @(negedge CLK);
    check_outputs("reset", 40'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;

    // CMD0 at full rate
    arm();
    send(F_CMD0, 48, 1, 0, mk(40'h40_0000_0000, 7'h4A, 1'b0, 1'b0, 1'b0), 1'b1);
    drain("drain_cmd0", 20);

    // CMD8, strobe every 3rd cycle, 5 idle-high bits first
    arm();
    send(F_CMD8, 48, 3, 5, mk(40'h48_0000_01AA, 7'h43, 1'b0, 1'b0, 1'b0), 1'b1);
    drain("drain_cmd8", 20);

    // argument bit flipped: CRC mismatch
    arm();
    send(F_CMD0_ARG, 48, 1, 0, mk(40'h40_0000_0001, 7'h4A, 1'b1, 1'b0, 1'b0), 1'b1);
    drain("drain_crcerr", 20);

    // end bit low: framing error only
    arm();
    send(F_CMD0_END, 48, 2, 0, mk(40'h40_0000_0000, 7'h4A, 1'b0, 1'b1, 1'b0), 1'b1);
    drain("drain_frameerr", 20);

`ifdef SD_RSP_TIMEOUT_EN
    // 64 idle-high strobes: timeout one cycle after the last one,
    // previous rsp/crc retained
    arm();
    for (int i = 0; i < 64; i++) begin
      @(negedge CLK); bit_en = 1'b1; cmd_i = 1'b1;
      if (i == 63) begin
        e = mk(40'h40_0000_0000, 7'h4A, 1'b0, 1'b0, 1'b1);
        e.cyc = cyc + 1;
        sb.push_back(e);
      end
    end
    @(negedge CLK); bit_en = 1'b0;
    drain("drain_timeout", 10);
    last_to = 1'b1;
`else
    // no timeout: a frame after 70 idle-high bits is still received
    arm();
    send(F_CMD0, 48, 1, 70, mk(40'h40_0000_0000, 7'h4A, 1'b0, 1'b0, 1'b0), 1'b1);
    drain("drain_notimeout", 20);
    last_to = 1'b0;
`endif

    // Enable dropped after bit 20: no done, results unchanged
    arm();
    send(F_CMD0_ARG, 21, 1, 0, e, 1'b0);
    Enable = 1'b0;
    repeat (60) @(negedge CLK);
    check_outputs("abort", 40'h40_0000_0000, 7'h4A, 1'b0, 1'b0, last_to);

    // reset after bit 30: no done, reset values
    arm();
    send(F_CMD0_ARG, 31, 1, 0, e, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    check_outputs("midreset", 40'h0, 7'h0, 1'b0, 1'b0, 1'b0);
    RST = 1'b1;
    repeat (5) @(negedge CLK);

    // clean CMD0 after both aborts
    arm();
    send(F_CMD0, 48, 1, 0, mk(40'h40_0000_0000, 7'h4A, 1'b0, 1'b0, 1'b0), 1'b1);
    drain("drain_recover", 20);

    repeat (20) @(negedge CLK);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
